// File: rtl/amo_lrsc_unit.sv
// Data-cache execute stage: computes AMO/store results, lane-replicated write data and mask,
// the sign-extended load value, and owns the single LR/SC reservation (timeout + snoop kill).
module amo_lrsc_unit #(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 40,
    parameter int BLOCK_OFF   = 6,
    parameter int LRSC_CYCLES = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [XLEN-1:0]   resp_wdata,
    output logic [XLEN/8-1:0] resp_wmask,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_sc_fail,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr
);

    localparam logic [4:0] M_XWR     = 5'h01;
    localparam logic [4:0] M_XA_SWAP = 5'h04;
    localparam logic [4:0] M_XLR     = 5'h06;
    localparam logic [4:0] M_XSC     = 5'h07;
    localparam logic [4:0] M_XA_ADD  = 5'h08;
    localparam logic [4:0] M_XA_XOR  = 5'h09;
    localparam logic [4:0] M_XA_OR   = 5'h0a;
    localparam logic [4:0] M_XA_AND  = 5'h0b;
    localparam logic [4:0] M_XA_MIN  = 5'h0c;
    localparam logic [4:0] M_XA_MAX  = 5'h0d;
    localparam logic [4:0] M_XA_MINU = 5'h0e;
    localparam logic [4:0] M_XA_MAXU = 5'h0f;
    localparam logic [4:0] M_PWR     = 5'h11;

    localparam int BLK_W = ADDR_W - BLOCK_OFF;
    localparam int CNT_W = $clog2(LRSC_CYCLES + 1);

    logic              resp_valid_q, resp_write_q, resp_sc_fail_q;
    logic [XLEN-1:0]   resp_wdata_q, resp_rdata_q;
    logic [XLEN/8-1:0] resp_wmask_q;

    logic              resv_valid_q, resv_valid_d;
    logic [BLK_W-1:0]  resv_blk_q, resv_blk_d;
    logic [CNT_W-1:0]  resv_cnt_q, resv_cnt_d;

    logic              accept, snoop_hit, sc_ok;
    logic [BLK_W-1:0]  req_blk, snp_blk;
    logic [2:0]        off;
    logic [XLEN-1:0]   old_shift, old_zx, old_sx, op_zx, op_sx, new_val;
    logic              old_lt_s, op_lt_s, old_lt_u, op_lt_u;
    logic [XLEN/8-1:0] size_mask;

    logic              write_d, sc_fail_d;
    logic [XLEN-1:0]   wdata_d, rdata_d;
    logic [XLEN/8-1:0] wmask_d;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[BLOCK_OFF-1:3], snoop_addr[BLOCK_OFF-1:0]};

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;

    assign req_blk   = req_addr[ADDR_W-1:BLOCK_OFF];
    assign snp_blk   = snoop_addr[ADDR_W-1:BLOCK_OFF];
    assign snoop_hit = snoop_valid && (snp_blk == resv_blk_q);
    // A snoop landing in the same cycle as the SC already kills it.
    assign sc_ok     = resv_valid_q && (resv_cnt_q != '0) && (req_blk == resv_blk_q) && !snoop_hit;

    assign off       = req_addr[2:0];
    assign old_shift = req_rdata >> {off, 3'b000};

    always_comb begin
        old_zx    = old_shift;
        old_sx    = old_shift;
        op_zx     = req_wdata;
        op_sx     = req_wdata;
        size_mask = 8'hFF;
        case (req_size)
            2'd0: begin
                old_zx    = {{(XLEN-8){1'b0}}, old_shift[7:0]};
                old_sx    = {{(XLEN-8){old_shift[7]}}, old_shift[7:0]};
                op_zx     = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                op_sx     = {{(XLEN-8){req_wdata[7]}}, req_wdata[7:0]};
                size_mask = 8'h01;
            end
            2'd1: begin
                old_zx    = {{(XLEN-16){1'b0}}, old_shift[15:0]};
                old_sx    = {{(XLEN-16){old_shift[15]}}, old_shift[15:0]};
                op_zx     = {{(XLEN-16){1'b0}}, req_wdata[15:0]};
                op_sx     = {{(XLEN-16){req_wdata[15]}}, req_wdata[15:0]};
                size_mask = 8'h03;
            end
            2'd2: begin
                old_zx    = {{(XLEN-32){1'b0}}, old_shift[31:0]};
                old_sx    = {{(XLEN-32){old_shift[31]}}, old_shift[31:0]};
                op_zx     = {{(XLEN-32){1'b0}}, req_wdata[31:0]};
                op_sx     = {{(XLEN-32){req_wdata[31]}}, req_wdata[31:0]};
                size_mask = 8'h0F;
            end
            default: ;
        endcase
    end

    // Extending to full width first lets one comparator serve both operand sizes.
    assign old_lt_s = $signed(old_sx) < $signed(op_sx);
    assign op_lt_s  = $signed(op_sx) < $signed(old_sx);
    assign old_lt_u = old_zx < op_zx;
    assign op_lt_u  = op_zx < old_zx;

    always_comb begin
        new_val   = op_zx;
        write_d   = 1'b0;
        sc_fail_d = 1'b0;
        rdata_d   = old_sx;
        case (req_cmd)
            M_XWR, M_PWR, M_XA_SWAP: write_d = 1'b1;
            M_XA_ADD: begin write_d = 1'b1; new_val = old_zx + op_zx; end
            M_XA_XOR: begin write_d = 1'b1; new_val = old_zx ^ op_zx; end
            M_XA_OR:  begin write_d = 1'b1; new_val = old_zx | op_zx; end
            M_XA_AND: begin write_d = 1'b1; new_val = old_zx & op_zx; end
            M_XA_MIN: begin write_d = 1'b1; new_val = op_lt_s  ? op_zx : old_zx; end
            M_XA_MAX: begin write_d = 1'b1; new_val = old_lt_s ? op_zx : old_zx; end
            M_XA_MINU: begin write_d = 1'b1; new_val = op_lt_u  ? op_zx : old_zx; end
            M_XA_MAXU: begin write_d = 1'b1; new_val = old_lt_u ? op_zx : old_zx; end
            M_XSC: begin
                if (sc_ok) begin
                    write_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    sc_fail_d = 1'b1;
                    rdata_d   = XLEN'(1);
                end
            end
            default: ;
        endcase
    end

    // Replication drops the carry-out of narrow ADDs for free.
    always_comb begin
        case (req_size)
            2'd0:    wdata_d = {(XLEN/8){new_val[7:0]}};
            2'd1:    wdata_d = {(XLEN/16){new_val[15:0]}};
            2'd2:    wdata_d = {(XLEN/32){new_val[31:0]}};
            default: wdata_d = new_val;
        endcase
    end

    assign wmask_d = size_mask << off;

    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_blk_d   = resv_blk_q;
        resv_cnt_d   = resv_cnt_q;
        if (accept && req_cmd == M_XLR) begin
            resv_valid_d = 1'b1;
            resv_blk_d   = req_blk;
            resv_cnt_d   = CNT_W'(LRSC_CYCLES);
        end else if ((accept && req_cmd == M_XSC) || snoop_hit) begin
            resv_valid_d = 1'b0;
            resv_cnt_d   = '0;
        end else if (resv_valid_q && resv_cnt_q != '0) begin
            resv_cnt_d = resv_cnt_q - 1'b1;
            if (resv_cnt_q == CNT_W'(1)) resv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_blk_q   <= '0;
            resv_cnt_q   <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_blk_q   <= resv_blk_d;
            resv_cnt_q   <= resv_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q   <= 1'b0;
            resp_write_q   <= 1'b0;
            resp_sc_fail_q <= 1'b0;
            resp_wdata_q   <= '0;
            resp_rdata_q   <= '0;
            resp_wmask_q   <= '0;
        end else if (accept) begin
            resp_valid_q   <= 1'b1;
            resp_write_q   <= write_d;
            resp_sc_fail_q <= sc_fail_d;
            resp_wdata_q   <= wdata_d;
            resp_rdata_q   <= rdata_d;
            resp_wmask_q   <= wmask_d;
        end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_write   = resp_write_q;
    assign resp_sc_fail = resp_sc_fail_q;
    assign resp_wdata   = resp_wdata_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_wmask   = resp_wmask_q;

endmodule

// File: tb/tb_amo_lrsc_unit.sv
// Bench for amo_lrsc_unit: hand-computed vector table, directed LR/SC/stall/reset
// sequences, and a randomized stream checked against a transaction-level model.
module tb_amo_lrsc_unit;

    localparam int LRSC = 80;

    localparam logic [4:0] M_XRD     = 5'h00;
    localparam logic [4:0] M_XWR     = 5'h01;
    localparam logic [4:0] M_PFR     = 5'h02;
    localparam logic [4:0] M_XA_SWAP = 5'h04;
    localparam logic [4:0] M_XLR     = 5'h06;
    localparam logic [4:0] M_XSC     = 5'h07;
    localparam logic [4:0] M_XA_ADD  = 5'h08;
    localparam logic [4:0] M_XA_XOR  = 5'h09;
    localparam logic [4:0] M_XA_OR   = 5'h0a;
    localparam logic [4:0] M_XA_AND  = 5'h0b;
    localparam logic [4:0] M_XA_MIN  = 5'h0c;
    localparam logic [4:0] M_XA_MAX  = 5'h0d;
    localparam logic [4:0] M_XA_MINU = 5'h0e;
    localparam logic [4:0] M_XA_MAXU = 5'h0f;
    localparam logic [4:0] M_FLUSH   = 5'h10;
    localparam logic [4:0] M_PWR     = 5'h11;
    localparam logic [4:0] M_CLEAN   = 5'h13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_cmd;
    logic [39:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata, req_rdata;
    logic        resp_valid, resp_ready, resp_write, resp_sc_fail;
    logic [63:0] resp_wdata, resp_rdata;
    logic [7:0]  resp_wmask;
    logic        snoop_valid;
    logic [39:0] snoop_addr;

    always #5 clk = ~clk;

    amo_lrsc_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_rdata(req_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_wdata(resp_wdata), .resp_wmask(resp_wmask), .resp_rdata(resp_rdata),
        .resp_sc_fail(resp_sc_fail), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
    );

    typedef struct {
        logic        wr;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic [63:0] rd;
        logic        scf;
    } resp_t;

    typedef struct {
        logic [4:0]  cmd;
        logic [39:0] addr;
        logic [1:0]  size;
        logic [63:0] wd;
        logic [63:0] rd;
        resp_t       exp;
    } vec_t;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic resp_t mkr(input logic wr, input logic [63:0] wd, input logic [7:0] wm,
                                  input logic [63:0] rd, input logic scf);
        resp_t r;
        r.wr = wr; r.wd = wd; r.wm = wm; r.rd = rd; r.scf = scf;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [4:0] cmd, input logic [39:0] addr, input logic [1:0] size,
                                 input logic [63:0] wd, input logic [63:0] rd, input resp_t e);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.size = size; v.wd = wd; v.rd = rd; v.exp = e;
        return v;
    endfunction

    // Reference: operate on the selected lane as plain integers, then replicate.
    function automatic resp_t model(input logic [4:0] cmd, input logic [39:0] addr, input logic [1:0] size,
                                    input logic [63:0] wd, input logic [63:0] rd, input bit sc_ok);
        resp_t r;
        int nb, bits, off;
        logic [63:0] wm, old, op, nv;
        longint so, sp;
        nb   = 1 << size;
        bits = 8 * nb;
        off  = int'(addr[2:0]);
        wm   = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        old  = (rd >> (8 * off)) & wm;
        op   = wd & wm;
        so   = old[bits-1] ? longint'(old | ~wm) : longint'(old);
        sp   = op[bits-1]  ? longint'(op | ~wm)  : longint'(op);
        nv    = op;
        r.wr  = 1'b0;
        r.rd  = 64'(so);
        r.scf = 1'b0;
        case (cmd)
            M_XWR, M_PWR, M_XA_SWAP: r.wr = 1'b1;
            M_XA_ADD:  begin r.wr = 1'b1; nv = (old + op) & wm; end
            M_XA_XOR:  begin r.wr = 1'b1; nv = old ^ op; end
            M_XA_OR:   begin r.wr = 1'b1; nv = old | op; end
            M_XA_AND:  begin r.wr = 1'b1; nv = old & op; end
            M_XA_MIN:  begin r.wr = 1'b1; nv = (so <= sp) ? old : op; end
            M_XA_MAX:  begin r.wr = 1'b1; nv = (so >= sp) ? old : op; end
            M_XA_MINU: begin r.wr = 1'b1; nv = (old <= op) ? old : op; end
            M_XA_MAXU: begin r.wr = 1'b1; nv = (old >= op) ? old : op; end
            M_XSC: begin
                if (sc_ok) begin r.wr = 1'b1; r.rd = 64'd0; end
                else begin r.rd = 64'd1; r.scf = 1'b1; end
            end
            default: ;
        endcase
        r.wd = '0;
        for (int i = 0; i < 8 / nb; i++) r.wd = r.wd | (nv << (bits * i));
        r.wm = 8'(((1 << nb) - 1) << off);
        return r;
    endfunction

    task automatic check_resp(input string nm, input resp_t e);
        chk({nm, ".valid"}, 64'(resp_valid), 64'd1);
        chk({nm, ".write"}, 64'(resp_write), 64'(e.wr));
        chk({nm, ".scfail"}, 64'(resp_sc_fail), 64'(e.scf));
        chk({nm, ".rdata"}, resp_rdata, e.rd);
        if (e.wr) begin
            chk({nm, ".wdata"}, resp_wdata, e.wd);
            chk({nm, ".wmask"}, 64'(resp_wmask), 64'(e.wm));
        end
    endtask

    task automatic txn(input logic [4:0] c, input logic [39:0] a, input logic [1:0] s,
                       input logic [63:0] wd, input logic [63:0] rd, input logic snp, input logic [39:0] sa);
        req_valid = 1'b1; req_cmd = c; req_addr = a; req_size = s; req_wdata = wd; req_rdata = rd;
        snoop_valid = snp; snoop_addr = sa; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; snoop_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; snoop_valid = 1'b0; resp_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    vec_t        vt[$];
    resp_t       q[$];
    resp_t       ea, eb;
    bit          rv, ok, acc, rr, snp_hit;
    logic [33:0] rblk, qblk, sblk;
    int          lr_cyc, nb, sel;
    logic [4:0]  cmds[19];

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_rdata = '0; resp_ready = 1'b1; snoop_valid = 1'b0; snoop_addr = '0;

        vt.push_back(mkv(M_XA_ADD,  40'h1004, 2, 64'h1, 64'h7FFFFFFF_00000000,
                         mkr(1, 64'h80000000_80000000, 8'hF0, 64'h00000000_7FFFFFFF, 0)));
        vt.push_back(mkv(M_XA_MIN,  40'h1000, 3, 64'h5, 64'hFFFFFFFF_FFFFFFFF,
                         mkr(1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 0)));
        vt.push_back(mkv(M_XA_MINU, 40'h1000, 3, 64'h5, 64'hFFFFFFFF_FFFFFFFF,
                         mkr(1, 64'h5, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 0)));
        vt.push_back(mkv(M_XRD,     40'h1003, 0, 64'h0, 64'h00112233_44556677,
                         mkr(0, 64'h0, 8'h0, 64'h44, 0)));
        vt.push_back(mkv(M_XRD,     40'h1006, 1, 64'h0, 64'h80001111_22223333,
                         mkr(0, 64'h0, 8'h0, 64'hFFFFFFFF_FFFF8000, 0)));
        vt.push_back(mkv(M_XWR,     40'h1002, 1, 64'h1234ABCD, 64'h0,
                         mkr(1, 64'hABCDABCD_ABCDABCD, 8'h0C, 64'h0, 0)));
        vt.push_back(mkv(M_XWR,     40'h1005, 0, 64'hFF5A, 64'h00008000_00000000,
                         mkr(1, 64'h5A5A5A5A_5A5A5A5A, 8'h20, 64'hFFFFFFFF_FFFFFF80, 0)));
        vt.push_back(mkv(M_XA_MAX,  40'h1000, 2, 64'h1, 64'h00000000_80000000,
                         mkr(1, 64'h00000001_00000001, 8'h0F, 64'hFFFFFFFF_80000000, 0)));
        vt.push_back(mkv(M_XA_MAXU, 40'h1000, 2, 64'h1, 64'h00000000_80000000,
                         mkr(1, 64'h80000000_80000000, 8'h0F, 64'hFFFFFFFF_80000000, 0)));
        vt.push_back(mkv(M_XA_AND,  40'h1000, 3, 64'hFF00FF00_FF00FF00, 64'hF0F0F0F0_F0F0F0F0,
                         mkr(1, 64'hF000F000_F000F000, 8'hFF, 64'hF0F0F0F0_F0F0F0F0, 0)));
        vt.push_back(mkv(M_XA_XOR,  40'h1004, 2, 64'hFFFFFFFF_0000FFFF, 64'h12345678_00000000,
                         mkr(1, 64'h1234A987_1234A987, 8'hF0, 64'h12345678, 0)));
        vt.push_back(mkv(M_XA_SWAP, 40'h1000, 2, 64'hDEADBEEF, 64'hAAAAAAAA_CAFEF00D,
                         mkr(1, 64'hDEADBEEF_DEADBEEF, 8'h0F, 64'hFFFFFFFF_CAFEF00D, 0)));
        vt.push_back(mkv(M_PWR,     40'h1008, 3, 64'h01234567_89ABCDEF, 64'h5,
                         mkr(1, 64'h01234567_89ABCDEF, 8'hFF, 64'h5, 0)));
        vt.push_back(mkv(M_FLUSH,   40'h1000, 3, 64'h0, 64'h80000000_00000001,
                         mkr(0, 64'h0, 8'h0, 64'h80000000_00000001, 0)));
        vt.push_back(mkv(M_XA_OR,   40'h1000, 2, 64'h0F0F0000, 64'hFFFFFFFF_000000F0,
                         mkr(1, 64'h0F0F00F0_0F0F00F0, 8'h0F, 64'hF0, 0)));
        vt.push_back(mkv(M_XA_ADD,  40'h1000, 3, 64'h2, 64'hFFFFFFFF_FFFFFFFF,
                         mkr(1, 64'h1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 0)));
        vt.push_back(mkv(M_XA_MINU, 40'h1004, 2, 64'h10, 64'h00000003_FFFFFFFF,
                         mkr(1, 64'h00000003_00000003, 8'hF0, 64'h3, 0)));

        repeat (2) @(negedge clk);
        chk("reset.valid",  64'(resp_valid),   64'd0);
        chk("reset.write",  64'(resp_write),   64'd0);
        chk("reset.scfail", 64'(resp_sc_fail), 64'd0);
        chk("reset.wdata",  resp_wdata,        64'd0);
        chk("reset.wmask",  64'(resp_wmask),   64'd0);
        chk("reset.rdata",  resp_rdata,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(M_XSC, 40'h5000, 3, 64'h1, 64'h0, 0, 0);
        check_resp("sc_cold", mkr(0, 0, 0, 64'd1, 1));

        foreach (vt[i]) begin
            txn(vt[i].cmd, vt[i].addr, vt[i].size, vt[i].wd, vt[i].rd, 0, 0);
            check_resp($sformatf("vec%0d", i), vt[i].exp);
        end

        txn(M_XLR, 40'h2000, 3, 64'h0, 64'h55, 0, 0);
        check_resp("lr", mkr(0, 0, 0, 64'h55, 0));
        idle(9);
        txn(M_XSC, 40'h2038, 3, 64'hCAFE, 64'h0, 0, 0);
        check_resp("sc_ok", mkr(1, 64'hCAFE, 8'hFF, 64'd0, 0));
        txn(M_XSC, 40'h2000, 3, 64'hCAFE, 64'h0, 0, 0);
        check_resp("sc_again", mkr(0, 0, 0, 64'd1, 1));

        txn(M_XLR, 40'h3000, 2, 64'h0, 64'h0, 0, 0);
        idle(79);
        txn(M_XSC, 40'h3000, 2, 64'h7, 64'h0, 0, 0);
        check_resp("sc_last_cycle", mkr(1, 64'h00000007_00000007, 8'h0F, 64'd0, 0));
        txn(M_XLR, 40'h3000, 2, 64'h0, 64'h0, 0, 0);
        idle(80);
        txn(M_XSC, 40'h3000, 2, 64'h7, 64'h0, 0, 0);
        check_resp("sc_expired", mkr(0, 0, 0, 64'd1, 1));

        txn(M_XLR, 40'h3000, 3, 64'h0, 64'h0, 0, 0);
        idle(4);
        snoop_valid = 1'b1; snoop_addr = 40'h3010;
        @(negedge clk);
        snoop_valid = 1'b0;
        idle(2);
        txn(M_XSC, 40'h3000, 3, 64'h9, 64'h0, 0, 0);
        check_resp("sc_snooped", mkr(0, 0, 0, 64'd1, 1));
        txn(M_XLR, 40'h3000, 3, 64'h0, 64'h0, 1, 40'h3010);
        idle(2);
        txn(M_XSC, 40'h3000, 3, 64'h9, 64'h0, 0, 0);
        check_resp("sc_lr_snoop_race", mkr(1, 64'h9, 8'hFF, 64'd0, 0));
        txn(M_XLR, 40'h3000, 3, 64'h0, 64'h0, 0, 0);
        txn(M_XSC, 40'h3000, 3, 64'h9, 64'h0, 1, 40'h3020);
        check_resp("sc_snoop_same", mkr(0, 0, 0, 64'd1, 1));
        txn(M_XLR, 40'h3000, 3, 64'h0, 64'h0, 0, 0);
        txn(M_XSC, 40'h3000, 3, 64'h9, 64'h0, 1, 40'h3040);
        check_resp("sc_snoop_other", mkr(1, 64'h9, 8'hFF, 64'd0, 0));
        idle(1);

        ea = mkr(0, 0, 0, 64'hA5, 0);
        eb = mkr(1, 64'h77, 8'hFF, 64'hB6, 0);
        req_valid = 1'b1; req_cmd = M_XRD; req_addr = 40'h1000; req_size = 3;
        req_wdata = 64'h0; req_rdata = 64'hA5; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_cmd = M_XWR; req_wdata = 64'h77; req_rdata = 64'hB6;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall.ready", 64'(req_ready), 64'd0);
            check_resp("stall.A", ea);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_resp("stall.B", eb);
        @(negedge clk);
        chk("stall.drain", 64'(resp_valid), 64'd0);

        txn(M_XLR, 40'h2000, 3, 64'h0, 64'h0, 0, 0);
        idle(1);
        req_valid = 1'b1; req_cmd = M_XRD; req_addr = 40'h2000; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_stall.valid", 64'(resp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async.valid", 64'(resp_valid), 64'd0);
        chk("rst_async.rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; resp_ready = 1'b1;
        txn(M_XSC, 40'h2000, 3, 64'h1, 64'h0, 0, 0);
        check_resp("sc_after_rst", mkr(0, 0, 0, 64'd1, 1));

        // Randomized phase starts from a clean reset so the model's reservation is known.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0; rblk = '0; lr_cyc = 0;
        cmds = '{M_XRD, M_XWR, M_PWR, M_XLR, M_XLR, M_XSC, M_XSC, M_XA_SWAP, M_XA_ADD,
                 M_XA_XOR, M_XA_OR, M_XA_AND, M_XA_MIN, M_XA_MAX, M_XA_MINU, M_XA_MAXU,
                 M_FLUSH, M_CLEAN, M_PFR};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rr = !((cyc % 11) inside {3, 4, 5}) && ($urandom_range(0, 4) != 0);
            resp_ready = rr;
            req_valid  = ($urandom_range(0, 3) != 0);
            sel        = int'($urandom_range(0, 18));
            req_cmd    = cmds[sel];
            if ((req_cmd >= M_XA_ADD && req_cmd <= M_XA_MAXU) || req_cmd == M_XA_SWAP ||
                req_cmd == M_XLR || req_cmd == M_XSC)
                req_size = 2'(2 + $urandom_range(0, 1));
            else
                req_size = 2'($urandom_range(0, 3));
            nb = 1 << req_size;
            req_addr   = 40'h4000 + 40'($urandom_range(0, 3) * 64) + 40'($urandom_range(0, 7) * 8)
                       + 40'(int'($urandom_range(0, 7)) & ~(nb - 1));
            req_wdata  = {$urandom, $urandom};
            req_rdata  = {$urandom, $urandom};
            snoop_valid = ($urandom_range(0, 7) == 0);
            snoop_addr  = 40'h4000 + 40'($urandom_range(0, 255));
            #1;
            chk("rnd.ready", 64'(req_ready), 64'((q.size() == 0) || rr));
            chk("rnd.valid", 64'(resp_valid), 64'(q.size() != 0));
            if (q.size() != 0) check_resp($sformatf("rnd%0d", cyc), q[0]);
            acc = req_valid && ((q.size() == 0) || rr);
            if (q.size() != 0 && rr) void'(q.pop_front());
            qblk    = req_addr[39:6];
            sblk    = snoop_addr[39:6];
            snp_hit = snoop_valid && (sblk == rblk);
            if (acc) begin
                ok = rv && (cyc - lr_cyc <= LRSC) && (qblk == rblk) && !snp_hit;
                q.push_back(model(req_cmd, req_addr, req_size, req_wdata, req_rdata, ok));
                if (req_cmd == M_XLR) begin
                    rv = 1; rblk = qblk; lr_cyc = cyc;
                end else if (req_cmd == M_XSC || snp_hit) begin
                    rv = 0;
                end
            end else if (snp_hit) begin
                rv = 0;
            end
            @(negedge clk);
        end
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
